// File: rtl/regfile_pkg.sv
// Shared types and sizing helpers for the multi-port register bank.
package regfile_pkg;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } state_t;

   // Width of the sequential clear counter for a bank of the given depth.
   function automatic int unsigned cnt_width(input int unsigned depth);
      return (depth <= 1) ? 1 : $clog2(depth);
   endfunction

endpackage

// File: rtl/regfile_fwd_mux.sv
// Per-read-port select: zero register / out-of-range, write bypass, array data.
module regfile_fwd_mux #(
   parameter int unsigned DATA_SIZE  = 32,
   parameter int unsigned ADDR_SIZE  = 5,
   parameter int unsigned BANK_DEPTH = 32,
   parameter int unsigned NUM_WR     = 2,
   parameter int unsigned ZERO_REG   = 1
) (
   input  logic [ADDR_SIZE-1:0]           rd_addr,
   input  logic [NUM_WR-1:0]              we,
   input  logic [NUM_WR*ADDR_SIZE-1:0]    wr_addr,
   input  logic [NUM_WR*DATA_SIZE-1:0]    wr_data,
   input  logic [DATA_SIZE-1:0]           arr_data,
   output logic [DATA_SIZE-1:0]           rd_data_c
);

   // Higher write ports are scanned later so the highest matching index wins.
   always_comb begin
      rd_data_c = arr_data;
      for (int p = 0; p < NUM_WR; p++) begin
         if (we[p] && (wr_addr[p*ADDR_SIZE +: ADDR_SIZE] == rd_addr))
            rd_data_c = wr_data[p*DATA_SIZE +: DATA_SIZE];
      end
      if (((ZERO_REG != 0) && (rd_addr == '0)) || (32'(rd_addr) >= BANK_DEPTH))
         rd_data_c = '0;
   end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register bank with write bypass, debug read port and clear engine.
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int unsigned DATA_SIZE  = 32,
   parameter int unsigned ADDR_SIZE  = 5,
   parameter int unsigned BANK_DEPTH = 32,
   parameter int unsigned NUM_RD     = 2,
   parameter int unsigned NUM_WR     = 2,
   parameter int unsigned ZERO_REG   = 1
) (
   input  logic                          i_clock,
   input  logic                          i_reset,
   input  logic                          i_enable,
   input  logic [NUM_WR-1:0]             i_we,
   input  logic [NUM_WR*ADDR_SIZE-1:0]   i_wr_addr,
   input  logic [NUM_WR*DATA_SIZE-1:0]   i_wr_data,
   input  logic [NUM_RD*ADDR_SIZE-1:0]   i_rd_addr,
   output logic [NUM_RD*DATA_SIZE-1:0]   o_rd_data,
   input  logic                          i_dbg_read_enable,
   input  logic [ADDR_SIZE-1:0]          i_dbg_addr,
   output logic [DATA_SIZE-1:0]          o_dbg_data,
   output logic                          o_dbg_valid,
   input  logic                          i_clear,
   output logic                          o_busy
);

   localparam int unsigned CNT_W = cnt_width(BANK_DEPTH);

   logic [DATA_SIZE-1:0]          regs [BANK_DEPTH];
   state_t                        state, state_nxt;
   logic [CNT_W-1:0]              clr_cnt, clr_cnt_nxt;
   logic [NUM_RD*DATA_SIZE-1:0]   arr_rd_c;
   logic [NUM_RD*DATA_SIZE-1:0]   rd_data_c;

   function automatic logic in_range(input logic [ADDR_SIZE-1:0] a);
      return 32'(a) < BANK_DEPTH;
   endfunction

   function automatic logic wr_ok(input logic [ADDR_SIZE-1:0] a);
      return in_range(a) && !((ZERO_REG != 0) && (a == '0));
   endfunction

   for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      assign arr_rd_c[k*DATA_SIZE +: DATA_SIZE] =
         in_range(i_rd_addr[k*ADDR_SIZE +: ADDR_SIZE]) ?
         regs[CNT_W'(i_rd_addr[k*ADDR_SIZE +: ADDR_SIZE])] : '0;

      regfile_fwd_mux #(
         .DATA_SIZE  (DATA_SIZE),
         .ADDR_SIZE  (ADDR_SIZE),
         .BANK_DEPTH (BANK_DEPTH),
         .NUM_WR     (NUM_WR),
         .ZERO_REG   (ZERO_REG)
      ) u_fwd_mux (
         .rd_addr   (i_rd_addr[k*ADDR_SIZE +: ADDR_SIZE]),
         .we        (i_we),
         .wr_addr   (i_wr_addr),
         .wr_data   (i_wr_data),
         .arr_data  (arr_rd_c[k*DATA_SIZE +: DATA_SIZE]),
         .rd_data_c (rd_data_c[k*DATA_SIZE +: DATA_SIZE])
      );
   end

   // Register array: clear engine owns the write path while in CLEAR.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         for (int i = 0; i < BANK_DEPTH; i++) regs[i] <= '0;
      end else if (state == CLEAR) begin
         regs[clr_cnt] <= '0;
      end else if (i_enable) begin
         for (int p = 0; p < NUM_WR; p++) begin
            if (i_we[p] && wr_ok(i_wr_addr[p*ADDR_SIZE +: ADDR_SIZE]))
               regs[CNT_W'(i_wr_addr[p*ADDR_SIZE +: ADDR_SIZE])] <=
                  i_wr_data[p*DATA_SIZE +: DATA_SIZE];
         end
      end
   end

   always_ff @(posedge i_clock) begin
      if (i_reset)
         o_rd_data <= '0;
      else if ((state == IDLE) && i_enable)
         o_rd_data <= rd_data_c;
   end

   // Debug port reads the array directly: pre-write value, served in any state.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         o_dbg_data  <= '0;
         o_dbg_valid <= 1'b0;
      end else begin
         o_dbg_valid <= i_dbg_read_enable;
         if (i_dbg_read_enable)
            o_dbg_data <= in_range(i_dbg_addr) ? regs[CNT_W'(i_dbg_addr)] : '0;
      end
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state   <= IDLE;
         clr_cnt <= '0;
         o_busy  <= 1'b0;
      end else begin
         state   <= state_nxt;
         clr_cnt <= clr_cnt_nxt;
         o_busy  <= (state_nxt == CLEAR);
      end
   end

   always_comb begin
      state_nxt   = state;
      clr_cnt_nxt = clr_cnt;
      case (state)
         IDLE: begin
            if (i_clear) begin
               state_nxt   = CLEAR;
               clr_cnt_nxt = '0;
            end
         end
         CLEAR: begin
            if (clr_cnt == CNT_W'(BANK_DEPTH - 1)) begin
               state_nxt   = IDLE;
               clr_cnt_nxt = '0;
            end else begin
               clr_cnt_nxt = clr_cnt + CNT_W'(1);
            end
         end
         default: begin
            state_nxt   = IDLE;
            clr_cnt_nxt = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp (32x32, 2 read, 2 write ports).
module tb_regfile_mp;

   logic        i_clock;
   logic        i_reset;
   logic        i_enable;
   logic [1:0]  i_we;
   logic [9:0]  i_wr_addr;
   logic [63:0] i_wr_data;
   logic [9:0]  i_rd_addr;
   logic [63:0] o_rd_data;
   logic        i_dbg_read_enable;
   logic [4:0]  i_dbg_addr;
   logic [31:0] o_dbg_data;
   logic        o_dbg_valid;
   logic        i_clear;
   logic        o_busy;

   int checks = 0;
   int errors = 0;
   int n;

   regfile_mp #(
      .DATA_SIZE(32), .ADDR_SIZE(5), .BANK_DEPTH(32),
      .NUM_RD(2), .NUM_WR(2), .ZERO_REG(1)
   ) dut (
      .i_clock           (i_clock),
      .i_reset           (i_reset),
      .i_enable          (i_enable),
      .i_we              (i_we),
      .i_wr_addr         (i_wr_addr),
      .i_wr_data         (i_wr_data),
      .i_rd_addr         (i_rd_addr),
      .o_rd_data         (o_rd_data),
      .i_dbg_read_enable (i_dbg_read_enable),
      .i_dbg_addr        (i_dbg_addr),
      .o_dbg_data        (o_dbg_data),
      .o_dbg_valid       (o_dbg_valid),
      .i_clear           (i_clear),
      .o_busy            (o_busy)
   );

   initial i_clock = 1'b0;
   always #5 i_clock = ~i_clock;

   task automatic tick();
      @(posedge i_clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic wr(input int p, input logic en, input logic [4:0] a, input logic [31:0] d);
      i_we[p]              = en;
      i_wr_addr[p*5 +: 5]  = a;
      i_wr_data[p*32 +: 32] = d;
   endtask

   task automatic rd(input int k, input logic [4:0] a);
      i_rd_addr[k*5 +: 5] = a;
   endtask

   function automatic logic [31:0] rdo(input int k);
      return o_rd_data[k*32 +: 32];
   endfunction

   initial begin
      i_reset = 1'b1; i_enable = 1'b1; i_we = '0; i_wr_addr = '0; i_wr_data = '0;
      i_rd_addr = '0; i_dbg_read_enable = 1'b0; i_dbg_addr = '0; i_clear = 1'b0;
      tick(); tick();
      i_reset = 1'b0;
      check("reset_rd0", rdo(0), 32'h0);
      check("reset_rd1", rdo(1), 32'h0);
      check("reset_dbg_data", o_dbg_data, 32'h0);
      check("reset_dbg_valid", 32'(o_dbg_valid), 32'h0);
      check("reset_busy", 32'(o_busy), 32'h0);

      // Write r5 then read it from the array on port 1
      wr(0, 1'b1, 5'd5, 32'hDEADBEEF);
      tick();
      wr(0, 1'b0, 5'd0, 32'h0);
      rd(1, 5'd5);
      tick();
      check("r5_array_rd1", rdo(1), 32'hDEADBEEF);

      // Same-cycle bypass from port 1
      wr(1, 1'b1, 5'd9, 32'h00001234);
      rd(0, 5'd9);
      tick();
      check("bypass_r9_rd0", rdo(0), 32'h00001234);
      check("r5_hold_rd1", rdo(1), 32'hDEADBEEF);

      // Two ports to r7: highest index wins for both bypass and array
      wr(0, 1'b1, 5'd7, 32'h11);
      wr(1, 1'b1, 5'd7, 32'h22);
      rd(0, 5'd7);
      tick();
      check("r7_bypass_prio", rdo(0), 32'h22);
      wr(0, 1'b0, 5'd0, 32'h0);
      wr(1, 1'b0, 5'd0, 32'h0);
      rd(1, 5'd7);
      i_dbg_read_enable = 1'b1; i_dbg_addr = 5'd7;
      tick();
      check("r7_array_rd1", rdo(1), 32'h22);
      check("r7_dbg_data", o_dbg_data, 32'h22);
      check("r7_dbg_valid", 32'(o_dbg_valid), 32'h1);

      // Zero register: write ignored, bypass blocked
      i_dbg_read_enable = 1'b0;
      wr(0, 1'b1, 5'd0, 32'hFFFFFFFF);
      rd(0, 5'd0);
      tick();
      check("r0_bypass_blocked", rdo(0), 32'h0);
      check("dbg_valid_drop", 32'(o_dbg_valid), 32'h0);
      wr(0, 1'b0, 5'd0, 32'h0);
      i_dbg_read_enable = 1'b1; i_dbg_addr = 5'd0;
      rd(1, 5'd0);
      tick();
      check("r0_rd1", rdo(1), 32'h0);
      check("r0_dbg", o_dbg_data, 32'h0);

      // Stall: write and read suppressed, debug still served
      i_dbg_read_enable = 1'b0;
      wr(0, 1'b1, 5'd3, 32'hA);
      rd(0, 5'd5);
      tick();
      check("r5_rd0", rdo(0), 32'hDEADBEEF);
      i_enable = 1'b0;
      wr(0, 1'b1, 5'd3, 32'h5);
      rd(0, 5'd3);
      i_dbg_read_enable = 1'b1; i_dbg_addr = 5'd3;
      tick();
      check("stall_rd0_hold", rdo(0), 32'hDEADBEEF);
      check("stall_dbg_r3", o_dbg_data, 32'hA);
      check("stall_dbg_valid", 32'(o_dbg_valid), 32'h1);
      i_enable = 1'b1;
      wr(0, 1'b0, 5'd0, 32'h0);
      i_dbg_read_enable = 1'b0;
      tick();
      check("post_stall_r3", rdo(0), 32'hA);
      check("post_stall_dbg_valid", 32'(o_dbg_valid), 32'h0);

      // Debug read returns pre-write value when a write lands the same cycle
      wr(1, 1'b1, 5'd3, 32'hB);
      i_dbg_read_enable = 1'b1; i_dbg_addr = 5'd3;
      tick();
      check("dbg_prewrite_r3", o_dbg_data, 32'hA);
      wr(1, 1'b0, 5'd0, 32'h0);
      tick();
      check("dbg_postwrite_r3", o_dbg_data, 32'hB);
      check("dbg_b2b_valid", 32'(o_dbg_valid), 32'h1);
      i_dbg_read_enable = 1'b0;

      // Fill r0..r31 with their index
      for (int i = 0; i < 32; i++) begin
         wr(0, 1'b1, 5'(i), 32'(i));
         tick();
      end
      wr(0, 1'b0, 5'd0, 32'h0);
      i_dbg_read_enable = 1'b1; i_dbg_addr = 5'd31;
      rd(0, 5'd31);
      i_clear = 1'b1;
      tick();
      i_clear = 1'b0;
      check("fill_dbg_r31", o_dbg_data, 32'd31);
      check("fill_rd0_r31", rdo(0), 32'd31);
      i_dbg_read_enable = 1'b0;

      // Clear engine: busy duration, writes dropped, read port held
      wr(0, 1'b1, 5'd20, 32'hBAD);
      wr(1, 1'b1, 5'd2, 32'hBAD2);
      rd(0, 5'd20);
      n = 0;
      while (o_busy && n < 100) begin
         n++;
         tick();
      end
      check("clear_busy_cycles", 32'(n), 32'd32);
      check("clear_rd0_held", rdo(0), 32'd31);
      wr(0, 1'b0, 5'd0, 32'h0);
      wr(1, 1'b0, 5'd0, 32'h0);
      for (int i = 0; i < 32; i++) begin
         rd(0, 5'(i));
         rd(1, 5'(31 - i));
         i_dbg_read_enable = 1'b1; i_dbg_addr = 5'(i);
         tick();
         check($sformatf("cleared_rd0_r%0d", i), rdo(0), 32'h0);
         check($sformatf("cleared_dbg_r%0d", i), o_dbg_data, 32'h0);
      end
      i_dbg_read_enable = 1'b0;

      // Reset during clear
      wr(0, 1'b1, 5'd1, 32'h111);
      wr(1, 1'b1, 5'd30, 32'h333);
      tick();
      wr(0, 1'b0, 5'd0, 32'h0);
      wr(1, 1'b0, 5'd0, 32'h0);
      rd(0, 5'd30);
      rd(1, 5'd1);
      tick();
      check("pre_clr_r30", rdo(0), 32'h333);
      check("pre_clr_r1", rdo(1), 32'h111);
      i_clear = 1'b1;
      tick();
      i_clear = 1'b0;
      for (int i = 0; i < 10; i++) tick();
      check("midclear_busy", 32'(o_busy), 32'h1);
      i_reset = 1'b1;
      tick();
      i_reset = 1'b0;
      check("rst_mid_busy", 32'(o_busy), 32'h0);
      check("rst_mid_rd0", rdo(0), 32'h0);
      check("rst_mid_rd1", rdo(1), 32'h0);
      wr(1, 1'b1, 5'd12, 32'h77);
      rd(0, 5'd30);
      rd(1, 5'd1);
      tick();
      check("rst_r30_zero", rdo(0), 32'h0);
      check("rst_r1_zero", rdo(1), 32'h0);
      check("rst_busy_stays0", 32'(o_busy), 32'h0);
      wr(1, 1'b0, 5'd0, 32'h0);
      rd(0, 5'd12);
      tick();
      check("rst_new_write_r12", rdo(0), 32'h77);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
